// File: rtl/mips_branch_predictor.sv
// IF-stage branch predictor: a direct-mapped branch target buffer with saturating
// direction counters, trained from ID, plus resolved/mispredicted branch counters.
module mips_branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int TAG_BITS = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      lookup_pc,
    output logic             lookup_hit,
    output logic             lookup_taken,
    output logic [31:0]      lookup_next_pc,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_target,
    input  logic             clear,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int IDX = $clog2(ENTRIES);

    // Reset leaves counters weakly not-taken; allocation starts weakly taken.
    localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;

    logic [ENTRIES-1:0]  validQ;
    logic [TAG_BITS-1:0] tagQ    [ENTRIES];
    logic [CTR_BITS-1:0] ctrQ    [ENTRIES];
    logic [29:0]         targetQ [ENTRIES];

    logic [IDX-1:0]      lookupIdx;
    logic [TAG_BITS-1:0] lookupTag;
    logic [IDX-1:0]      updIdx;
    logic [TAG_BITS-1:0] updTag;
    logic                updHit;
    logic                mispredict;
    logic                unusedBits;

    assign lookupIdx = lookup_pc[IDX+1:2];
    assign lookupTag = lookup_pc[IDX+TAG_BITS+1:IDX+2];
    assign updIdx    = upd_pc[IDX+1:2];
    assign updTag    = upd_pc[IDX+TAG_BITS+1:IDX+2];
    assign unusedBits = ^upd_pc;

    always_comb begin
        lookup_hit     = validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag);
        lookup_taken   = lookup_hit && ctrQ[lookupIdx][CTR_BITS-1];
        lookup_next_pc = lookup_taken ? {targetQ[lookupIdx], 2'b00} : lookup_pc + 32'd4;
    end

    assign updHit     = validQ[updIdx] && (tagQ[updIdx] == updTag);
    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tagQ[i]    <= '0;
                ctrQ[i]    <= CTR_RST;
                targetQ[i] <= '0;
            end
        end else if (clear) begin
            validQ <= '0;
        end else if (upd_valid) begin
            if (updHit) begin
                if (upd_taken) begin
                    if (ctrQ[updIdx] != CTR_MAX)
                        ctrQ[updIdx] <= ctrQ[updIdx] + CTR_BITS'(1);
                    targetQ[updIdx] <= upd_target[31:2];
                end else if (ctrQ[updIdx] != '0) begin
                    ctrQ[updIdx] <= ctrQ[updIdx] - CTR_BITS'(1);
                end
            end else if (upd_taken) begin
                validQ[updIdx]  <= 1'b1;
                tagQ[updIdx]    <= updTag;
                ctrQ[updIdx]    <= CTR_ALLOC;
                targetQ[updIdx] <= upd_target[31:2];
            end
        end
    end

    // Statistics ignore clear so a flush does not lose accounting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (upd_valid)
                branch_count <= branch_count + CNT_W'(1);
            if (mispredict)
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mips_branch_predictor.sv
// Scoreboard bench for mips_branch_predictor: directed scenarios then random traffic
// checked against a table-level reference model.
module tb_mips_branch_predictor;
    localparam int ENTRIES   = 16;
    localparam int CTR_BITS  = 2;
    localparam int TAG_BITS  = 8;
    localparam int IDX       = $clog2(ENTRIES);
    localparam int CTR_MAX   = (1 << CTR_BITS) - 1;
    localparam int CTR_ALLOC = 1 << (CTR_BITS - 1);

    logic        clk = 0;
    logic        reset = 0;
    logic [31:0] lookup_pc = '0;
    logic        lookup_hit, lookup_taken;
    logic [31:0] lookup_next_pc;
    logic        upd_valid = 0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 0;
    logic [31:0] upd_pred_target = '0;
    logic        clear = 0;
    logic [31:0] branch_count, mispredict_count;

    mips_branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .TAG_BITS(TAG_BITS), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .lookup_hit(lookup_hit),
        .lookup_taken(lookup_taken), .lookup_next_pc(lookup_next_pc), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .clear(clear),
        .branch_count(branch_count), .mispredict_count(mispredict_count));

    always #5 clk = ~clk;

    // Reference model: the table as plain arrays, counters as integers.
    bit          mValid [ENTRIES];
    int unsigned mTag   [ENTRIES];
    int          mCtr   [ENTRIES];
    bit [31:0]   mTgt   [ENTRIES];
    bit [31:0]   mBc, mMc;

    typedef struct {
        bit        hit;
        bit        tk;
        bit [31:0] npc;
        bit [31:0] bc;
        bit [31:0] mc;
    } exp_t;
    exp_t sbq[$];

    int nChecks = 0;
    int nFails  = 0;

    function automatic int unsigned idxOf(bit [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tagOf(bit [31:0] pc);
        return (pc >> (2 + IDX)) % (1 << TAG_BITS);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 0; mTag[i] = 0; mCtr[i] = CTR_ALLOC - 1; mTgt[i] = '0;
        end
        mBc = '0; mMc = '0;
    endtask

    task automatic predict(input bit [31:0] pc, output bit hit, output bit tk, output bit [31:0] npc);
        int unsigned i;
        i   = idxOf(pc);
        hit = mValid[i] && (mTag[i] == tagOf(pc));
        tk  = hit && (mCtr[i] >= CTR_ALLOC);
        npc = tk ? (mTgt[i] & 32'hFFFF_FFFC) : pc + 32'd4;
    endtask

    task automatic modelUpdate(input bit uv, input bit [31:0] upc, input bit ut, input bit [31:0] utgt,
                               input bit upt, input bit [31:0] uptgt, input bit clr);
        int unsigned i;
        bit hit;
        if (uv) begin
            mBc = mBc + 1;
            if ((upt != ut) || (ut && (uptgt != utgt))) mMc = mMc + 1;
        end
        if (clr) begin
            for (int k = 0; k < ENTRIES; k++) mValid[k] = 0;
        end else if (uv) begin
            i   = idxOf(upc);
            hit = mValid[i] && (mTag[i] == tagOf(upc));
            if (hit && ut) begin
                mCtr[i] = (mCtr[i] + 1 > CTR_MAX) ? CTR_MAX : mCtr[i] + 1;
                mTgt[i] = utgt;
            end else if (hit) begin
                mCtr[i] = (mCtr[i] - 1 < 0) ? 0 : mCtr[i] - 1;
            end else if (ut) begin
                mValid[i] = 1; mTag[i] = tagOf(upc); mCtr[i] = CTR_ALLOC; mTgt[i] = utgt;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a fresh result every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("lookup_hit", {31'b0, lookup_hit}, {31'b0, e.hit});
            chk("lookup_taken", {31'b0, lookup_taken}, {31'b0, e.tk});
            chk("lookup_next_pc", lookup_next_pc, e.npc);
            chk("branch_count", branch_count, e.bc);
            chk("mispredict_count", mispredict_count, e.mc);
        end
    end

    // One cycle of stimulus; inputs are sampled by the following rising edge.
    task automatic step(input bit [31:0] lpc, input bit uv, input bit [31:0] upc, input bit ut,
                        input bit [31:0] utgt, input bit upt, input bit [31:0] uptgt,
                        input bit clr, input bit arst);
        exp_t e;
        @(posedge clk); #1;
        lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        upd_pred_taken = upt; upd_pred_target = uptgt; clear = clr;
        if (arst) begin
            #2;
            reset = 0;
            modelReset();
        end
        predict(lpc, e.hit, e.tk, e.npc);
        e.bc = mBc; e.mc = mMc;
        sbq.push_back(e);
        if (reset) modelUpdate(uv, upc, ut, utgt, upt, uptgt, clr);
    endtask

    task automatic releaseReset();
        @(posedge clk); #1;
        reset = 1; upd_valid = 0; clear = 0;
    endtask

    function automatic bit [31:0] randPc();
        bit [31:0] pc;
        pc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2);
        if ($urandom_range(0, 7) == 0) pc = pc | 32'h0010_0000;
        return pc;
    endfunction

    initial begin
        bit [31:0] lpc, upc, utgt, ptg;
        bit uv, ut, pt, h, clr, ars;
        modelReset();
        repeat (2) @(posedge clk);
        #1 reset = 1;

        // Basic allocate / saturate / decay on 0x40
        step(32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        step(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0);
        step(32'h40, 1, 32'h40, 1, 32'h80, 0, 32'h44, 0, 0);
        step(32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        step(32'h440, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(32'h40, 1, 32'h40, 1, 32'h80, 1, 32'h80, 0, 0);
        repeat (2) step(32'h40, 1, 32'h40, 0, 32'h80, 1, 32'h80, 0, 0);
        step(32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        // Same-cycle update and lookup: no bypass
        step(32'h40, 1, 32'h40, 1, 32'hC0, 0, 32'h44, 0, 0);
        step(32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        // Clear beats a simultaneous allocation but still counts
        step(32'h40, 1, 32'h100, 1, 32'h200, 0, 32'h104, 1, 0);
        step(32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
        step(32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        // Rebuild state, then asynchronous reset between edges
        step(32'h40, 1, 32'h40, 1, 32'h80, 0, 32'h44, 0, 0);
        step(32'h40, 1, 32'h40, 1, 32'h80, 0, 32'h44, 0, 1);
        releaseReset();
        step(32'h40, 1, 32'h40, 1, 32'h80, 0, 32'h44, 0, 0);
        step(32'h40, 1, 32'h40, 0, 32'h80, 1, 32'h80, 0, 0);
        step(32'h40, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            lpc  = randPc();
            upc  = ($urandom_range(0, 1) == 0) ? lpc : randPc();
            uv   = ($urandom_range(0, 3) != 0);
            ut   = ($urandom_range(0, 2) != 0);
            utgt = 32'h1000 + ($urandom_range(0, 7) << 4);
            if ($urandom_range(0, 15) == 0) utgt[1:0] = 2'($urandom);
            if ($urandom_range(0, 1) == 0) predict(upc, h, pt, ptg);
            else begin
                pt  = 1'($urandom);
                ptg = 32'h1000 + ($urandom_range(0, 7) << 4);
            end
            clr = ($urandom_range(0, 49) == 0);
            ars = ($urandom_range(0, 399) == 0);
            step(lpc, uv, upc, ut, utgt, pt, ptg, clr, ars);
            if (ars) releaseReset();
        end

        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk);
        @(negedge clk); #1;
        if (sbq.size() != 0) chk("scoreboard_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
